// File: rtl/output_driver_multi.sv
// Multi-channel phase-armed pulse scheduler: per channel, arm on a tooth phase, wait a delay,
// then drive a registered output high for a duration. Optional on-time clamp: OUTDRV_DWELL_LIMIT_EN.
module output_driver_multi #(
  parameter int unsigned       N_CH    = 4,
  parameter int unsigned       PHASE_W = 8,
  parameter int unsigned       TIME_W  = 24,
  parameter logic [TIME_W-1:0] MAX_ON  = TIME_W'(100000)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      synced,
  input  logic [PHASE_W-1:0]        eng_phase,
  input  logic                      trigger,
  input  logic [N_CH-1:0]           enable,
  input  logic [N_CH*PHASE_W-1:0]   cfg_phase,
  input  logic [N_CH*TIME_W-1:0]    cfg_delay,
  input  logic [N_CH*TIME_W-1:0]    cfg_duration,
  output logic [N_CH-1:0]           out,
  output logic [N_CH-1:0]           overrun,
  output logic [N_CH-1:0]           limited
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StDelay = 2'd1;
  localparam logic [1:0] StOn    = 2'd2;

  logic [N_CH-1:0][1:0]        state_q, state_d;
  logic [N_CH-1:0][TIME_W-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0][TIME_W-1:0] dur_q, dur_d;
  logic [N_CH-1:0]             out_q, out_d;
  logic [N_CH-1:0]             ovr_pend_q, ovr_pend_d;
  logic [N_CH-1:0]             lim_pend_q, lim_pend_d;
  logic [N_CH-1:0]             overrun_q, overrun_d;
  logic [N_CH-1:0]             limited_q, limited_d;

  logic [N_CH-1:0]             arm;
  logic [N_CH-1:0]             clamp;
  logic [N_CH-1:0][TIME_W-1:0] dur_sel;
  logic [N_CH-1:0][TIME_W-1:0] dly_sel;

  always_comb begin
    arm     = '0;
    clamp   = '0;
    dur_sel = '0;
    dly_sel = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      arm[i] = synced & enable[i] & trigger &
               (eng_phase == cfg_phase[i*PHASE_W +: PHASE_W]);
      dly_sel[i] = cfg_delay[i*TIME_W +: TIME_W];
`ifdef OUTDRV_DWELL_LIMIT_EN
      if (cfg_duration[i*TIME_W +: TIME_W] > MAX_ON) begin
        dur_sel[i] = MAX_ON;
        clamp[i]   = 1'b1;
      end else begin
        dur_sel[i] = cfg_duration[i*TIME_W +: TIME_W];
      end
`else
      dur_sel[i] = cfg_duration[i*TIME_W +: TIME_W];
`endif
    end
  end

  // Output and flags lag the state by one register stage so that an arm sampled at edge 0
  // shows its effects from cycle 1 onward.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dur_d      = dur_q;
    out_d      = '0;
    ovr_pend_d = '0;
    lim_pend_d = '0;
    overrun_d  = ovr_pend_q;
    limited_d  = lim_pend_q;
    for (int i = 0; i < int'(N_CH); i++) begin
      out_d[i] = synced & (state_q[i] == StOn);
      if (!synced) begin
        state_d[i] = StIdle;
        cnt_d[i]   = '0;
      end else begin
        case (state_q[i])
          StIdle: begin
            if (arm[i] && (dur_sel[i] != '0)) begin
              dur_d[i]      = dur_sel[i];
              lim_pend_d[i] = clamp[i];
              if (dly_sel[i] == '0) begin
                state_d[i] = StOn;
                cnt_d[i]   = dur_sel[i];
              end else begin
                state_d[i] = StDelay;
                cnt_d[i]   = dly_sel[i];
              end
            end
          end
          StDelay: begin
            ovr_pend_d[i] = arm[i];
            if (cnt_q[i] == TIME_W'(1)) begin
              state_d[i] = StOn;
              cnt_d[i]   = dur_q[i];
            end else begin
              cnt_d[i] = cnt_q[i] - TIME_W'(1);
            end
          end
          StOn: begin
            ovr_pend_d[i] = arm[i];
            if (cnt_q[i] == TIME_W'(1)) begin
              state_d[i] = StIdle;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_q[i] - TIME_W'(1);
            end
          end
          default: begin
            state_d[i] = StIdle;
            cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= '0;
      cnt_q      <= '0;
      dur_q      <= '0;
      out_q      <= '0;
      ovr_pend_q <= '0;
      lim_pend_q <= '0;
      overrun_q  <= '0;
      limited_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dur_q      <= dur_d;
      out_q      <= out_d;
      ovr_pend_q <= ovr_pend_d;
      lim_pend_q <= lim_pend_d;
      overrun_q  <= overrun_d;
      limited_q  <= limited_d;
    end
  end

  assign out     = out_q;
  assign overrun = overrun_q;
  assign limited = limited_q;

endmodule

// File: tb/tb_output_driver_multi.sv
// Directed bench for output_driver_multi: pulse placement, overrun, config latch, sync loss,
// reset and the optional dwell clamp (OUTDRV_DWELL_LIMIT_EN).
module tb_output_driver_multi;

  localparam int N  = 4;
  localparam int PW = 8;
  localparam int TW = 24;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            synced = 1'b1;
  logic [PW-1:0]   eng_phase = '0;
  logic            trigger = 1'b0;
  logic [N-1:0]    enable = '0;
  logic [N*PW-1:0] cfg_phase = '0;
  logic [N*TW-1:0] cfg_delay = '0;
  logic [N*TW-1:0] cfg_duration = '0;
  logic [N-1:0]    out;
  logic [N-1:0]    overrun;
  logic [N-1:0]    limited;

  int checks = 0;
  int failures = 0;

  int rise[N], fall[N], rise2[N], highs[N];
  int ovr_n[N], ovr_first[N], lim_n[N], lim_first[N];

  output_driver_multi #(
    .N_CH   (N),
    .PHASE_W(PW),
    .TIME_W (TW),
    .MAX_ON (24'd1000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .synced      (synced),
    .eng_phase   (eng_phase),
    .trigger     (trigger),
    .enable      (enable),
    .cfg_phase   (cfg_phase),
    .cfg_delay   (cfg_delay),
    .cfg_duration(cfg_duration),
    .out         (out),
    .overrun     (overrun),
    .limited     (limited)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    for (int c = 0; c < N; c++) begin
      rise[c] = -1; fall[c] = -1; rise2[c] = -1; highs[c] = 0;
      ovr_n[c] = 0; ovr_first[c] = -1; lim_n[c] = 0; lim_first[c] = -1;
    end
  endtask

  // Advance one edge and record what the outputs show in cycle k.
  task automatic step(input int k);
    tick();
    for (int c = 0; c < N; c++) begin
      if (out[c]) begin
        highs[c]++;
        if (rise[c] < 0) rise[c] = k;
        else if (fall[c] >= 0 && rise2[c] < 0) rise2[c] = k;
      end else if (rise[c] >= 0 && fall[c] < 0) begin
        fall[c] = k;
      end
      if (overrun[c]) begin
        ovr_n[c]++;
        if (ovr_first[c] < 0) ovr_first[c] = k;
      end
      if (limited[c]) begin
        lim_n[c]++;
        if (lim_first[c] < 0) lim_first[c] = k;
      end
    end
  endtask

  // Trigger sampled at the next edge, which becomes edge 0.
  task automatic fire(input int phase);
    eng_phase = PW'(phase);
    trigger   = 1'b1;
    tick();
    trigger   = 1'b0;
    clear_stats();
  endtask

  task automatic set_ch(input int c, input int ph, input int dly, input int dur);
    cfg_phase[c*PW +: PW]    = PW'(ph);
    cfg_delay[c*TW +: TW]    = TW'(dly);
    cfg_duration[c*TW +: TW] = TW'(dur);
  endtask

  int exp_w;
  int exp_lim;

  initial begin
`ifdef OUTDRV_DWELL_LIMIT_EN
    exp_w   = 1000;
    exp_lim = 1;
`else
    exp_w   = 5000;
    exp_lim = 0;
`endif
    set_ch(0, 30, 1000, 5000);
    set_ch(1, 40, 0, 10);
    set_ch(2, 40, 5, 0);
    set_ch(3, 50, 7, 7);
    repeat (3) tick();
    check("reset_out", out, 0);
    check("reset_overrun", overrun, 0);
    check("reset_limited", limited, 0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Basic pulse (and dwell clamp when enabled)
    enable = 4'b0001;
    fire(30);
    for (int k = 1; k <= 6200; k++) step(k);
    check("basic_rise", rise[0], 1001);
    check("basic_width", highs[0], exp_w);
    check("basic_fall", fall[0], 1001 + exp_w);
    check("basic_limited_n", lim_n[0], exp_lim);
    if (exp_lim != 0) check("basic_limited_cycle", lim_first[0], 1);
    check("basic_others", highs[1] + highs[2] + highs[3], 0);
    check("basic_overrun", ovr_n[0], 0);

    // Zero delay and zero duration on the same trigger
    enable = 4'b0110;
    fire(40);
    for (int k = 1; k <= 30; k++) step(k);
    check("zd_rise", rise[1], 1);
    check("zd_width", highs[1], 10);
    check("zd_fall", fall[1], 11);
    check("zdur_highs", highs[2], 0);
    check("zdur_flags", ovr_n[2] + lim_n[2] + ovr_n[1] + lim_n[1], 0);
    check("zd_ch0_quiet", highs[0], 0);

    // Overrun, then earliest re-arm
    enable = 4'b0001;
    set_ch(0, 30, 10, 100);
    fire(30);
    for (int k = 1; k <= 130; k++) begin
      trigger = (k == 50 || k == 111);
      step(k);
    end
    trigger = 1'b0;
    check("ovr_rise", rise[0], 11);
    check("ovr_fall", fall[0], 111);
    check("ovr_count", ovr_n[0], 1);
    check("ovr_cycle", ovr_first[0], 51);
    check("rearm_rise", rise2[0], 122);
    repeat (150) tick();

    // Config latched at arm time
    set_ch(0, 30, 1000, 50);
    fire(30);
    for (int k = 1; k <= 1100; k++) begin
      if (k == 500) cfg_delay[0 +: TW] = TW'(20);
      step(k);
    end
    check("latch_rise", rise[0], 1001);
    check("latch_width", highs[0], 50);
    fire(30);
    for (int k = 1; k <= 100; k++) step(k);
    check("latch_next_rise", rise[0], 21);
    check("latch_next_width", highs[0], 50);

    // Sync loss mid-ON
    set_ch(0, 30, 5, 100);
    fire(30);
    for (int k = 1; k <= 200; k++) begin
      synced = (k != 31);
      step(k);
    end
    synced = 1'b1;
    check("sync_rise", rise[0], 6);
    check("sync_fall", fall[0], 31);
    check("sync_highs", highs[0], 25);
    check("sync_flags", ovr_n[0] + lim_n[0], 0);
    fire(30);
    for (int k = 1; k <= 120; k++) step(k);
    check("sync_restart_rise", rise[0], 6);
    check("sync_restart_width", highs[0], 100);

    // Asynchronous reset mid-ON
    fire(30);
    for (int k = 1; k <= 30; k++) step(k);
    check("rst_pre_high", out[0], 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_out", out[0], 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    fire(30);
    for (int k = 1; k <= 120; k++) step(k);
    check("rst_restart_rise", rise[0], 6);
    check("rst_restart_width", highs[0], 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/output_driver_multi.md
# output_driver_multi

Multi-channel, parametrised successor to `output_driver`. It sits downstream of `sync` and consumes `eng_phase`, `trigger` and `synced`. Each channel is armed when a programmed tooth phase is reached, waits a programmed delay in clock ticks, then drives its output high for a programmed duration. This lets ignition and injection outputs share one scheduler. Channels are fully independent, latch their configuration at arm time, and fail safe to low on loss of sync.

## Interface
- `N_CH`, 4: number of output channels (1–16).
- `PHASE_W`, 8: width of `eng_phase` and per-channel phase config.
- `TIME_W`, 24: width of delay/duration counters (clock ticks).
- `MAX_ON`, 24'd100000: on-time clamp in ticks; used only with `OUTDRV_DWELL_LIMIT_EN`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `synced`  in  1  crank sync valid from `sync`.
- `eng_phase`  in  PHASE_W  current tooth phase from `sync`.
- `trigger`  in  1  one-cycle tooth strobe from `sync`; `eng_phase` is valid in the same cycle.
- `enable`  in  N_CH  per-channel arm enable.
- `cfg_phase`  in  N_CH*PHASE_W  arm phase per channel; channel i occupies bits [i*PHASE_W +: PHASE_W].
- `cfg_delay`  in  N_CH*TIME_W  ticks from trigger to output rise.
- `cfg_duration`  in  N_CH*TIME_W  output high time in ticks.
- `out`  out  N_CH  channel outputs, active high, registered.
- `overrun`  out  N_CH  one-cycle pulse when a matching trigger arrives while the channel is busy.
- `limited`  out  N_CH  one-cycle pulse when the latched duration was clamped.

## Operation
- Per-channel FSM states: IDLE, DELAY, ON.
- **Arm condition:** `synced & enable[i] & trigger & (eng_phase == cfg_phase[i])`.
- **IDLE + arm:**
  - Latch `cfg_delay` and `cfg_duration`. Later config changes do not affect the event in flight.
  - If duration == 0: stay IDLE; no pulse, no flag.
  - Else if delay == 0: go to ON with counter = duration.
  - Else: go to DELAY with counter = delay.
- **DELAY:** decrement the counter each cycle. When it reaches 1, go to ON and load the latched duration.
- **ON:** `out[i]` = 1. Decrement the counter each cycle. When it reaches 1, return to IDLE; `out[i]` falls the next cycle.
- **Busy arm:** an arm condition seen in DELAY or ON is ignored and pulses `overrun[i]` for one cycle. The in-flight event is unaffected.
- **Enable deasserted mid-event:** the event completes. `enable` gates arming only.
- **Loss of sync:** `synced` = 0 in any cycle forces every channel to IDLE and `out` to 0 on the next edge, with no flags. Arming resumes on the first trigger after `synced` returns to 1.
- Channels never interact. Several channels may arm on the same trigger.
- Counters are TIME_W unsigned. A latched value of all-ones is a legal maximum. Counters never wrap.

## Timing
- **Reset:** all channels IDLE; `out`, `overrun`, `limited` = 0 while `rst_n` = 0 and immediately on assertion. Reset mid-pulse drops `out` asynchronously.
- **Pulse placement:** arm sampled at edge 0 with delay D and duration W ≥ 1 gives `out` high during cycles D+1 through D+W inclusive, exactly W cycles.
  - D = 0 gives a rise at cycle 1.
- **Earliest re-arm:** a channel is IDLE in cycle D+W+1 and accepts a trigger sampled there. A trigger sampled in cycle D+W (the last ON cycle) is an overrun.
- `overrun` and `limited` assert in cycle 1 relative to the arm or overrun edge.
- **Simultaneous events:** `synced` falling in the same cycle as an arm means the arm is discarded (sync loss wins).

## Configuration
- `OUTDRV_DWELL_LIMIT_EN` defined:
  - The latched duration is min(`cfg_duration`, `MAX_ON`).
  - When clamping occurs, `limited[i]` pulses in cycle 1.
- Undefined:
  - No clamp; `MAX_ON` is ignored.
  - `limited` is tied to 0.

## Test plan
- **Basic pulse:** N_CH = 4, ch0 phase 30, delay 1000, duration 5000, trigger at phase 30 → `out[0]` rises exactly 1001 cycles after the trigger edge and is high for 5000 cycles; other channels stay 0.
- **Zero-delay and zero-duration channels:** ch1 delay 0, duration 10 → high cycles 1..10. ch2 duration 0 → never high, no flags.
- **Overrun:** ch0 delay 10, duration 100. A second matching trigger 50 cycles later → `overrun[0]` pulses once and the original pulse ends at cycle 110 unchanged. A trigger at cycle 111 arms normally.
- **Config latch:** change `cfg_delay[0]` from 1000 to 20 during DELAY → the pulse still rises at cycle 1001. The next event uses 20.
- **Sync loss and reset:** drop `synced` mid-ON → `out` low next edge. Assert `rst_n` low mid-ON → `out` low without a clock edge. Both restart cleanly on the next trigger.
- **Dwell limit (macro defined, MAX_ON = 1000):** duration 5000 → high exactly 1000 cycles and `limited[0]` pulses. Macro undefined → high 5000 cycles and `limited` stays 0.
